// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int unsigned DEFAULT_WIDTH = 6;
    localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
    parameter int unsigned WIDTH = 6
) (
    input  logic [WIDTH-1:0] r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);

    logic [WIDTH:0] t;

    // The partial remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits.
    always_comb begin
        t      = {r, q_msb} - {1'b0, d};
        q_bit  = ~t[WIDTH];
        r_next = q_bit ? t[WIDTH-1:0] : {r[WIDTH-2:0], q_msb};
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned divider: one restoring step per clock, start/busy/done handshake.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned     CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] r_next;
    logic             q_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r),
        .q_msb  (q[WIDTH-1]),
        .d      (d),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // R is held in WIDTH bits: its extra top bit is always zero between steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        d   <= divisor;
                        q   <= dividend;
                        r   <= '0;
                        cnt <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r   <= r_next;
                    q   <= {q[WIDTH-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        quotient    <= {q[WIDTH-2:0], q_bit};
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Iterative unsigned divider for 6-bit operands; performs the inverse of the 6x6 array-multiplier datapath (partial product generation plus adder tree).
- Produces quotient and remainder with one restoring step per clock.
- Sits beside the multiplier in the arithmetic unit; a start/busy/done handshake drives it from the same controller.

Parameters:
- WIDTH, 6, operand, quotient and remainder width in bits (must be >= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  unsigned numerator; captured on accepted start.
- divisor  input  WIDTH  unsigned denominator; captured on accepted start.
- busy  output  1  high in RUN and DONE; low in IDLE.
- done  output  1  single-cycle pulse; results valid this cycle.
- quotient  output  WIDTH  registered result; held until next accepted start.
- remainder  output  WIDTH  registered result; held until next accepted start.
- div_by_zero  output  1  registered flag for last operation; held with the results.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy, done, div_by_zero, quotient, remainder and the internal count, R and D registers all go to 0.
  - Reset mid-operation discards the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1, capture D=divisor, Q=dividend, R=0 (WIDTH+1 bits), count=0.
  - If divisor==0, go to DONE. Otherwise go to RUN.
  - If start=0, remain in IDLE.
- RUN (exactly WIDTH cycles), one step per cycle:
  - R' = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - T = R' - {1'b0, D}, computed in WIDTH+1 bits.
  - If T[WIDTH]=1 (negative): R = R', Q = {Q[WIDTH-2:0], 0}.
  - Else: R = T, Q = {Q[WIDTH-2:0], 1}.
  - count increments each step. When count==WIDTH-1, go to DONE.
- DONE (one cycle):
  - done=1. quotient=Q, remainder=R[WIDTH-1:0], div_by_zero=0.
  - The result registers load on the transition into DONE, so they are valid while done=1.
  - Next state is always IDLE.
- Divide by zero:
  - Loaded on the transition IDLE->DONE: quotient = all ones, remainder = dividend, div_by_zero=1.
- Latency:
  - Start accepted at edge k: done=1 in cycle k+WIDTH+1.
  - Divide by zero: done=1 in cycle k+1.
- Throughput: a new start is accepted in the first IDLE cycle after DONE. Minimum issue spacing is WIDTH+2 cycles.
- Handshake:
  - start while busy=1 (RUN or DONE) is ignored and not queued.
  - Operand changes after acceptance do not affect the running operation.
- Invariants:
  - Outputs change only on an accepted operation's completion or on reset.
  - remainder < divisor whenever div_by_zero=0.
  - dividend == quotient*divisor + remainder.

Decomposition:
- Shared package (div_pkg):
  - state enum {IDLE, RUN, DONE}.
  - WIDTH default constant.
  - CNT_W = $clog2(WIDTH) constant.
- Sub-module div_step:
  - Purely combinational single restoring step.
  - Inputs R, Q msb, D. Outputs next R and the quotient bit.
  - Reused by a future unrolled/pipelined variant.
- Top module holds the FSM, counter, operand and result registers.

Test Plan:
- Reset, then 45/7, start pulsed at edge 0 -> done=1 in cycle 7 only; quotient=6, remainder=3, div_by_zero=0; busy high cycles 1-7.
- 63/1 -> quotient=63, remainder=0. Then 5/9 -> quotient=0, remainder=5. Outputs hold 63/0 between the two operations.
- 20/0 -> done in cycle 1; quotient=63, remainder=20, div_by_zero=1. A following 12/4 -> 3/0 with div_by_zero cleared.
- start held high continuously with operands 50/6 changed to 1/1 at cycle 2 -> first result 8/2. Second operation is accepted in the first IDLE cycle after DONE (cycle 8), results 1/0. No extra done pulses.
- Reset asserted asynchronously mid-RUN (cycle 3 of 33/5) -> all outputs 0 immediately, no done pulse. A subsequent 33/5 gives 6/3.
- Exhaustive sweep of all 4096 operand pairs against a reference model (a/b, a%b, zero-divisor rule). Check latency WIDTH+1 and exactly one done per accepted start.
